// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and requester owner encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MEM_I = 2'd1,
        S_MEM_D = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-side, data-side and memory-port signals around mem_arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshakes: if_req/d_req are levels held with their qualifiers until the matching
    // one-cycle if_valid/d_valid; mem_req is held with its qualifiers until mem_ack.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_byte;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic              mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata,
        output mem_req, mem_we, mem_byte, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata,
        input  mem_req, mem_we, mem_byte, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requesters.
// ARB_FAIR_EN: on contention the side that was not granted last wins; otherwise data wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

    logic prefer_d;

`ifdef ARB_FAIR_EN
    assign prefer_d = (last_owner == OWN_I);
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign prefer_d          = 1'b1;
`endif

    assign grant_valid = if_req | d_req;
    assign grant_owner = (d_req && (!if_req || prefer_d)) ? OWN_D : OWN_I;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one transaction in flight, registered memory port.
// ARB_FAIR_EN: adds a last_owner register so contention alternates between sides.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output state_t       dbg_state
);

    state_t            state_q, state_d;
    owner_t            owner_q, last_owner, grant_owner;
    logic              grant_valid, start, complete;
    logic              mem_req_q, mem_we_q, mem_byte_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;

    mem_arb_pick u_pick (
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

`ifdef ARB_FAIR_EN
    owner_t last_owner_q;
    always_ff @(posedge clk) begin
        if (reset)      last_owner_q <= OWN_I;
        else if (start) last_owner_q <= grant_owner;
    end
    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_I;
`endif

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    start   = 1'b1;
                    state_d = (grant_owner == OWN_D) ? S_MEM_D : S_MEM_I;
                end
            end
            S_MEM_I, S_MEM_D: begin
                if (bus.mem_ack) begin
                    complete = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Memory-port qualifiers are latched at grant so they stay stable while waiting for ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OWN_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else if (start) begin
            mem_req_q <= 1'b1;
            owner_q   <= grant_owner;
            if (grant_owner == OWN_D) begin
                mem_addr_q  <= bus.d_addr;
                mem_we_q    <= bus.d_we;
                mem_byte_q  <= bus.d_byte;
                mem_wdata_q <= bus.d_wdata;
            end else begin
                mem_addr_q <= bus.if_addr;
                mem_we_q   <= 1'b0;
                mem_byte_q <= 1'b0;
            end
        end else if (complete) begin
            mem_req_q <= 1'b0;
            if (owner_q == OWN_D) d_rdata_q  <= bus.mem_rdata;
            else                  if_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_byte  = mem_byte_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_valid  = (state_q == S_RESP) && (owner_q == OWN_I);
    assign bus.d_valid   = (state_q == S_RESP) && (owner_q == OWN_D);
    assign bus.busy      = (state_q != S_IDLE);
    assign dbg_state     = state_q;

endmodule
